// File: rtl/riscv_mem_pkg.sv
// Shared types and sizes for the two-port refill arbiter.
package riscv_mem_pkg;

  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned S_ADDR     = 10;

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StRespI,
    StRespD
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Line-transfer port: the requester side is master, the servicing side is slave.
interface riscv_mem_arbiter_if;
  import riscv_mem_pkg::*;

  logic                  rden;
  logic                  wren;
  logic [S_ADDR-1:0]     addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output rden,
    output wren,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  rden,
    input  wren,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );

endinterface

// File: rtl/riscv_arb_rr2.sv
// Two-input round-robin picker; on a tie the side not granted last wins.
module riscv_arb_rr2
  import riscv_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_imem,
  input  logic   req_dmem,
  input  logic   grant_en,
  output grant_e grant
);

  grant_e last_grant;

  always_comb begin
    grant = GNT_I;
    if (req_dmem && (!req_imem || (last_grant == GNT_I))) begin
      grant = GNT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_I;
    end else if (grant_en) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// I/D refill arbiter onto one line memory port; one transaction in flight,
// memory-side strobes and requester ready pulses are registered.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
(
  input logic                 i_riscv_arb_clk,
  input logic                 i_riscv_arb_rst,
  riscv_mem_arbiter_if.slave  imem,
  riscv_mem_arbiter_if.slave  dmem,
  riscv_mem_arbiter_if.master mem
);

  arb_state_e            state_q;
  logic                  mem_rden_q;
  logic                  mem_wren_q;
  logic                  imem_ready_q;
  logic                  dmem_ready_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic   imem_req;
  logic   dmem_req;
  logic   grant_en;
  op_e    dmem_op;
  grant_e grant;

  // A D-side request with both strobes set is a writeback.
  always_comb begin
    imem_req = imem.rden;
    dmem_req = dmem.rden | dmem.wren;
    dmem_op  = dmem.wren ? OP_WR : OP_RD;
    grant_en = (state_q == StIdle) && (imem_req || dmem_req);
  end

  riscv_arb_rr2 u_rr2 (
    .clk      (i_riscv_arb_clk),
    .rst      (i_riscv_arb_rst),
    .req_imem (imem_req),
    .req_dmem (dmem_req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  always_ff @(posedge i_riscv_arb_clk) begin
    if (i_riscv_arb_rst) begin
      state_q      <= StIdle;
      mem_rden_q   <= 1'b0;
      mem_wren_q   <= 1'b0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            if (grant == GNT_I) begin
              state_q    <= StBusyI;
              mem_rden_q <= 1'b1;
              mem_wren_q <= 1'b0;
              addr_q     <= imem.addr;
            end else begin
              state_q    <= StBusyD;
              mem_rden_q <= (dmem_op == OP_RD);
              mem_wren_q <= (dmem_op == OP_WR);
              addr_q     <= dmem.addr;
              wdata_q    <= dmem.wdata;
            end
          end
        end
        StBusyI, StBusyD: begin
          if (mem.ready) begin
            rdata_q    <= mem.rdata;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            if (state_q == StBusyI) begin
              state_q      <= StRespI;
              imem_ready_q <= 1'b1;
            end else begin
              state_q      <= StRespD;
              dmem_ready_q <= 1'b1;
            end
          end
        end
        // Ready is already high for this cycle; no grant is made here.
        StRespI, StRespD: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  assign mem.rden   = mem_rden_q;
  assign mem.wren   = mem_wren_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign imem.ready = imem_ready_q;
  assign dmem.ready = dmem_ready_q;
  assign imem.rdata = rdata_q;
  assign dmem.rdata = rdata_q;

endmodule
